// File: rtl/tsp_pkg.sv
// rtl/tsp_pkg.sv - shared TS packet constants, scheduler states and round-robin helper
package tsp_pkg;

  localparam int PACK_BYTE_SIZE = 188;
  localparam int PACK_WORD_SIZE = PACK_BYTE_SIZE / 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_PUMP = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_e;

  // Wraps a slot number that is at most one lap past the end of the slot range.
  function automatic int unsigned rr_wrap(input int unsigned x, input int unsigned n);
    return (x >= n) ? (x - n) : x;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter
  import tsp_pkg::*;
#(
  parameter int FILTER_NUM  = 64,
  parameter int INDEX_WIDTH = 6
) (
  input  logic [FILTER_NUM-1:0]  req_i,
  input  logic [INDEX_WIDTH-1:0] ptr_i,
  output logic [FILTER_NUM-1:0]  grant_o,
  output logic [INDEX_WIDTH-1:0] grant_idx_o,
  output logic                   grant_valid_o
);

  always_comb begin
    int unsigned k;
    k             = 0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int i = 0; i < FILTER_NUM; i++) begin
      k = rr_wrap(int'(ptr_i) + i, FILTER_NUM);
      if (!grant_valid_o && (((req_i >> k) & FILTER_NUM'(1)) != '0)) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = INDEX_WIDTH'(k);
      end
    end
    grant_o = grant_valid_o ? (FILTER_NUM'(1) << grant_idx_o) : '0;
  end

endmodule

// File: rtl/filter_read_scheduler.sv
// rtl/filter_read_scheduler.sv - round-robin owner of the shared 188-byte packet buffer
module filter_read_scheduler #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int FILTER_NUM         = 64,
  parameter int INDEX_WIDTH        = 6,
  parameter int PACK_WORD_SIZE     = tsp_pkg::PACK_WORD_SIZE,
  parameter int TIMEOUT_CYCLES     = 1023
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic                          enable,
  input  logic [FILTER_NUM-1:0]         slot_mask,
  input  logic [FILTER_NUM-1:0]         read_data_ready,
  output logic [FILTER_NUM-1:0]         pump_enable,
  input  logic                          word_valid,
  input  logic [7:0]                    word_index,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] word_data,
  output logic                          buf_wr_en,
  output logic [7:0]                    buf_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] buf_wr_data,
  output logic                          pkt_done,
  output logic [INDEX_WIDTH-1:0]        pkt_slot,
  input  logic                          host_ack,
  output logic                          busy,
  output logic                          timeout_err
);
  import tsp_pkg::*;

  localparam int              TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      WORDS = 8'(PACK_WORD_SIZE);
  localparam logic [TW-1:0]   T_MAX = TW'(TIMEOUT_CYCLES);

  sched_state_e                  state_q;
  logic [INDEX_WIDTH-1:0]        rr_ptr_q, grant_slot_q, pkt_slot_q;
  logic [7:0]                    word_cnt_q, buf_wr_addr_q;
  logic [TW-1:0]                 timer_q;
  logic [FILTER_NUM-1:0]         pump_enable_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] buf_wr_data_q;
  logic                          buf_wr_en_q, pkt_done_q, busy_q, timeout_err_q;

  logic [FILTER_NUM-1:0]         arb_grant;
  logic [INDEX_WIDTH-1:0]        arb_idx;
  logic                          arb_valid;
  logic [INDEX_WIDTH-1:0]        next_ptr_d;

  rr_arbiter #(
    .FILTER_NUM  (FILTER_NUM),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_rr_arbiter (
    .req_i         (read_data_ready & slot_mask),
    .ptr_i         (rr_ptr_q),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  assign next_ptr_d = INDEX_WIDTH'(rr_wrap(int'(grant_slot_q) + 1, FILTER_NUM));

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_slot_q  <= '0;
      pkt_slot_q    <= '0;
      word_cnt_q    <= '0;
      timer_q       <= '0;
      pump_enable_q <= '0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_data_q <= '0;
      pkt_done_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      buf_wr_en_q   <= 1'b0;
      pkt_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_ARB;
            busy_q  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (arb_valid) begin
            grant_slot_q  <= arb_idx;
            pump_enable_q <= arb_grant;
            word_cnt_q    <= '0;
            timer_q       <= '0;
            state_q       <= ST_PUMP;
          end else if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_PUMP: begin
          // Completion is seen one cycle after the last word so its buffer write has landed.
          if (word_cnt_q == WORDS) begin
            pump_enable_q <= '0;
            pkt_done_q    <= 1'b1;
            pkt_slot_q    <= grant_slot_q;
            rr_ptr_q      <= next_ptr_d;
            state_q       <= ST_HOLD;
          end else if (timer_q == T_MAX) begin
            pump_enable_q <= '0;
            timeout_err_q <= 1'b1;
            rr_ptr_q      <= next_ptr_d;
            state_q       <= ST_ARB;
          end else if (word_valid) begin
            timer_q <= '0;
            if (word_index < WORDS) begin
              buf_wr_en_q   <= 1'b1;
              buf_wr_addr_q <= word_index;
              buf_wr_data_q <= word_data;
              word_cnt_q    <= word_cnt_q + 8'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_HOLD: begin
          if (host_ack) begin
            state_q <= enable ? ST_ARB : ST_IDLE;
            busy_q  <= enable;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pump_enable = pump_enable_q;
  assign buf_wr_en   = buf_wr_en_q;
  assign buf_wr_addr = buf_wr_addr_q;
  assign buf_wr_data = buf_wr_data_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_slot    = pkt_slot_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_filter_read_scheduler.sv
// tb/tb_filter_read_scheduler.sv - scoreboard bench for filter_read_scheduler
module tb_filter_read_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] slot_mask = '1;
  logic [63:0] read_data_ready = '0;
  logic [63:0] pump_enable;
  logic        word_valid = 1'b0;
  logic [7:0]  word_index = '0;
  logic [31:0] word_data = '0;
  logic        buf_wr_en;
  logic [7:0]  buf_wr_addr;
  logic [31:0] buf_wr_data;
  logic        pkt_done;
  logic [5:0]  pkt_slot;
  logic        host_ack = 1'b0;
  logic        busy;
  logic        timeout_err;

  filter_read_scheduler dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESET    (rst),
    .enable          (enable),
    .slot_mask       (slot_mask),
    .read_data_ready (read_data_ready),
    .pump_enable     (pump_enable),
    .word_valid      (word_valid),
    .word_index      (word_index),
    .word_data       (word_data),
    .buf_wr_en       (buf_wr_en),
    .buf_wr_addr     (buf_wr_addr),
    .buf_wr_data     (buf_wr_data),
    .pkt_done        (pkt_done),
    .pkt_slot        (pkt_slot),
    .host_ack        (host_ack),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int to_count = 0;
  logic [63:0] prev_pump = '0;
  logic [39:0] exp_wr_q[$];
  int          exp_grant_q[$];
  int          exp_pkt_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_pump = '0;
    end else begin
      if (buf_wr_en) begin
        wr_count++;
        if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(buf_wr_en), 64'd0);
        else check("wr_addr_data", {24'd0, buf_wr_addr, buf_wr_data}, {24'd0, exp_wr_q.pop_front()});
      end
      if (pump_enable != 0 && prev_pump == 0) begin
        if (exp_grant_q.size() == 0) check("grant_unexpected", pump_enable, 64'd0);
        else check("grant", pump_enable, 64'd1 << exp_grant_q.pop_front());
      end
      if (pkt_done) begin
        if (exp_pkt_q.size() == 0) check("pkt_unexpected", 64'(pkt_done), 64'd0);
        else check("pkt_slot", 64'(pkt_slot), 64'(exp_pkt_q.pop_front()));
      end
      if (timeout_err) to_count++;
      prev_pump = pump_enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    int k;
    for (k = 0; k < 20; k++) begin
      tick();
      if (pump_enable != 0) break;
    end
    if (k == 20) check("grant_wait_expired", pump_enable, 64'd1);
  endtask

  task automatic drive_word(input logic [7:0] idx, input bit expect_write);
    tick();
    word_valid = 1'b1;
    word_index = idx;
    word_data  = $urandom;
    if (expect_write) exp_wr_q.push_back({idx, word_data});
  endtask

  // Sends words 0..nwords-1; a full packet is also checked for pkt_done two cycles after the last word.
  task automatic send_words(input int slot, input int nwords, input bit inject_bad);
    for (int i = 0; i < nwords; i++) begin
      if (inject_bad && i == 20) begin
        drive_word(8'd47, 1'b0);
        drive_word(8'd200, 1'b0);
      end
      if (i == 46) exp_pkt_q.push_back(slot);
      drive_word(8'(i), 1'b1);
    end
    tick();
    word_valid = 1'b0;
    if (nwords == 47) begin
      tick();
      check("pkt_done_t2", 64'(pkt_done), 64'd1);
      check("pump_low_at_done", pump_enable, 64'd0);
    end
  endtask

  task automatic pulse_ack();
    tick();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {pump_enable}, 64'd0);
    check({tag, "_misc"}, {22'd0, buf_wr_en, buf_wr_addr, buf_wr_data},
          64'd0);
    check({tag, "_flags"}, {56'd0, pkt_done, busy, timeout_err, 5'd0} | 64'(pkt_slot), 64'd0);
  endtask

  initial begin
    int k;
    int hold_viol;
    #12;
    check_outputs_zero("reset_initial");
    tick();
    rst = 1'b0;

    // Start a packet on slot 5 and reset part-way through it
    enable = 1'b1;
    read_data_ready[5] = 1'b1;
    exp_grant_q.push_back(5);
    wait_grant();
    send_words(5, 5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_pump");
    exp_wr_q.delete();
    tick();
    tick();
    rst = 1'b0;
    exp_grant_q.push_back(5);
    wr_count = 0;
    wait_grant();
    check("pump_slot5", pump_enable, 64'h20);
    send_words(5, 47, 1'b0);
    check("write_count", 64'(wr_count), 64'd47);
    read_data_ready = '0;
    pulse_ack();

    // Round-robin from a fresh pointer
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_data_ready = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 63);
    foreach (exp_grant_q[i]) check("grant_q_clear", 64'(exp_grant_q.size()), 64'd0);
    exp_grant_q = '{3, 10, 63, 3};
    for (int p = 0; p < 4; p++) begin
      wait_grant();
      send_words(p == 1 ? 10 : (p == 2 ? 63 : 3), 47, 1'b0);
      pulse_ack();
    end

    // Masked slot 10 is never granted
    slot_mask[10] = 1'b0;
    read_data_ready = (64'd1 << 3) | (64'd1 << 10);
    exp_grant_q.push_back(3);
    exp_grant_q.push_back(3);
    for (int p = 0; p < 2; p++) begin
      wait_grant();
      send_words(3, 47, 1'b0);
      pulse_ack();
    end
    slot_mask = '1;

    // Out-of-range word indices are dropped
    read_data_ready = 64'd1 << 3;
    exp_grant_q.push_back(3);
    wait_grant();
    send_words(3, 47, 1'b1);
    pulse_ack();

    // Timeout on slot 10, next grant moves on to slot 11
    read_data_ready = (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 11);
    exp_grant_q.push_back(10);
    wait_grant();
    exp_grant_q.push_back(11);
    send_words(10, 10, 1'b0);
    for (k = 1; k <= 1200; k++) begin
      if (timeout_err) break;
      tick();
    end
    check("timeout_window", 64'(k >= 1023 && k <= 1026), 64'd1);
    check("timeout_pump_low", pump_enable, 64'd0);
    check("timeout_busy", 64'(busy), 64'd1);
    wait_grant();
    send_words(11, 47, 1'b0);
    read_data_ready = 64'd1 << 3;
    exp_grant_q.push_back(3);
    pulse_ack();

    // enable dropped mid-packet, delayed host_ack
    wait_grant();
    enable = 1'b0;
    send_words(3, 47, 1'b0);
    hold_viol = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      if (pump_enable != 0 || !busy) hold_viol++;
    end
    check("hold_no_grant", 64'(hold_viol), 64'd0);
    tick();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    check("idle_after_ack", 64'(busy), 64'd0);
    for (int c = 0; c < 5; c++) tick();
    check("idle_no_pump", pump_enable, 64'd0);

    check("timeout_count", 64'(to_count), 64'd1);
    check("sb_wr_left", 64'(exp_wr_q.size()), 64'd0);
    check("sb_grant_left", 64'(exp_grant_q.size()), 64'd0);
    check("sb_pkt_left", 64'(exp_pkt_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got hung expected finish");
    $fatal(1);
  end

endmodule
